// File: rtl/wb_uart_fifo.sv
// wb_uart_fifo: Wishbone classic 8N1 UART with TX/RX FIFOs, runtime divisor and maskable interrupt.
// Optional internal loopback (IER[7]) is enabled by defining WB_UART_FIFO_LOOPBACK_EN.
module wb_uart_fifo #(
  parameter int          FIFO_DEPTH = 16,
  parameter int          DIV_WIDTH  = 16,
  parameter int unsigned DIV_RESET  = 434
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [31:0] wb_adr_i,
  input  logic [7:0]  wb_dat_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic [2:0]  wb_cti_i,
  input  logic [1:0]  wb_bte_i,
  output logic [7:0]  wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic        wb_rty_o,
  output logic        int_o,
  input  logic        rx,
  output logic        tx
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  logic [2:0] adr;
  logic req, term, adr_ok, wr, rd, unused_ok;
  logic [1:0] ier;
  logic [7:0] ier_rd, lsr, rdata, rx_q;
  logic [DIV_WIDTH-1:0] div, eff_div;
  logic ovr, fe;
  assign adr = wb_adr_i[2:0];
  assign req = wb_cyc_i & wb_stb_i;
  assign term = req & ~wb_ack_o & ~wb_err_o;
  assign adr_ok = adr != 3'd4 && adr < 3'd6;
  assign wr = term & adr_ok & wb_we_i;
  assign rd = term & adr_ok & ~wb_we_i;
  assign wb_rty_o = 1'b0;
  assign unused_ok = ^{wb_adr_i[31:3], wb_cti_i, wb_bte_i};
  assign eff_div = div < DIV_WIDTH'(2) ? DIV_WIDTH'(2) : div;
  logic [7:0] tx_mem [FIFO_DEPTH];
  logic [AW:0] tx_wp, tx_rp;
  logic tx_empty, tx_full, tx_push, tx_load, tx_end, tx_r;
  state_t tx_st;
  logic [DIV_WIDTH-1:0] tx_cnt, tx_bdiv;
  logic [2:0] tx_idx;
  logic [7:0] tx_sh;
  assign tx_empty = tx_wp == tx_rp;
  assign tx_full = (tx_wp ^ tx_rp) == {1'b1, {AW{1'b0}}};
  assign tx_end = tx_cnt == tx_bdiv - DIV_WIDTH'(1);
  assign tx_load = ~tx_empty & (tx_st == IDLE | (tx_st == STOP & tx_end));
  assign tx_push = wr & adr == 3'd0 & (~tx_full | tx_load);
  always_ff @(posedge wb_clk_i)
    if (tx_push) tx_mem[tx_wp[AW-1:0]] <= wb_dat_i;
  // A load out of STOP chains frames back to back without an idle bit.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i)
    if (wb_rst_i) begin
      tx_st <= IDLE;
      tx_r <= 1'b1;
      tx_cnt <= '0;
      tx_bdiv <= DIV_WIDTH'(DIV_RESET);
      tx_idx <= '0;
      tx_sh <= '0;
      tx_wp <= '0;
      tx_rp <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + (AW+1)'(1);
      if (tx_load) begin
        tx_st <= START;
        tx_r <= 1'b0;
        tx_sh <= tx_mem[tx_rp[AW-1:0]];
        tx_rp <= tx_rp + (AW+1)'(1);
        tx_cnt <= '0;
        tx_bdiv <= eff_div;
      end else if (tx_st != IDLE) begin
        if (tx_end) begin
          tx_cnt <= '0;
          tx_bdiv <= eff_div;
          tx_st <= tx_st == START ? DATA : tx_st == DATA ? (tx_idx == 3'd7 ? STOP : DATA) : IDLE;
          tx_r <= tx_st == START ? tx_sh[0] : (tx_st == DATA && tx_idx != 3'd7) ? tx_sh[1] : 1'b1;
          tx_idx <= tx_st == DATA ? tx_idx + 3'd1 : 3'd0;
          tx_sh <= tx_st == DATA ? tx_sh >> 1 : tx_sh;
        end else tx_cnt <= tx_cnt + DIV_WIDTH'(1);
      end
    end
  logic rx_s1, rx_s2, rx_d, rx_in;
  logic [7:0] rx_mem [FIFO_DEPTH];
  logic [AW:0] rx_wp, rx_rp;
  logic rx_empty, rx_full, rx_pop, rx_push, rx_stop, rx_end;
  state_t rx_st;
  logic [DIV_WIDTH-1:0] rx_cnt, rx_bdiv, rx_tgt;
  logic [2:0] rx_idx;
  logic [7:0] rx_sh;
  assign rx_empty = rx_wp == rx_rp;
  assign rx_full = (rx_wp ^ rx_rp) == {1'b1, {AW{1'b0}}};
  assign rx_tgt = rx_st == START ? rx_bdiv >> 1 : rx_bdiv;
  assign rx_end = rx_cnt == rx_tgt - DIV_WIDTH'(1);
  assign rx_stop = rx_st == STOP & rx_end;
  assign rx_pop = rd & adr == 3'd0 & ~rx_empty;
  assign rx_push = rx_stop & (~rx_full | rx_pop);
  assign rx_q = rx_empty ? 8'h00 : rx_mem[rx_rp[AW-1:0]];
  always_ff @(posedge wb_clk_i)
    if (rx_push) rx_mem[rx_wp[AW-1:0]] <= rx_sh;
  // START samples mid-bit so every later sample lands one full bit period on, at bit centre.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i)
    if (wb_rst_i) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_d <= 1'b1;
      rx_st <= IDLE;
      rx_cnt <= '0;
      rx_bdiv <= DIV_WIDTH'(DIV_RESET);
      rx_idx <= '0;
      rx_sh <= '0;
      rx_wp <= '0;
      rx_rp <= '0;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
      rx_d <= rx_in;
      if (rx_push) rx_wp <= rx_wp + (AW+1)'(1);
      if (rx_pop) rx_rp <= rx_rp + (AW+1)'(1);
      if (rx_st == IDLE) begin
        if (rx_d & ~rx_in) begin
          rx_st <= START;
          rx_cnt <= '0;
          rx_bdiv <= eff_div;
        end
      end else if (rx_end) begin
        rx_cnt <= '0;
        rx_bdiv <= eff_div;
        rx_st <= rx_st == START ? (rx_in ? IDLE : DATA) : rx_st == DATA ? (rx_idx == 3'd7 ? STOP : DATA) : IDLE;
        rx_idx <= rx_st == DATA ? rx_idx + 3'd1 : 3'd0;
        rx_sh <= rx_st == DATA ? {rx_in, rx_sh[7:1]} : rx_sh;
      end else rx_cnt <= rx_cnt + DIV_WIDTH'(1);
    end
`ifdef WB_UART_FIFO_LOOPBACK_EN
  logic lb;
  always_ff @(posedge wb_clk_i or posedge wb_rst_i)
    if (wb_rst_i) lb <= 1'b0;
    else if (wr && adr == 3'd1) lb <= wb_dat_i[7];
  assign tx = lb | tx_r;
  assign rx_in = lb ? tx_r : rx_s2;
  assign ier_rd = {lb, 5'b0, ier};
`else
  assign tx = tx_r;
  assign rx_in = rx_s2;
  assign ier_rd = {6'b0, ier};
`endif
  assign lsr = {1'b0, tx_empty & tx_st == IDLE, tx_empty, tx_full, fe, 1'b0, ovr, ~rx_empty};
  always_comb
    rdata = adr == 3'd0 ? rx_q : adr == 3'd1 ? ier_rd : adr == 3'd2 ? div[7:0] :
            adr == 3'd3 ? 8'(div[DIV_WIDTH-1:8]) : lsr;
  always_ff @(posedge wb_clk_i or posedge wb_rst_i)
    if (wb_rst_i) begin
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      wb_dat_o <= '0;
      ier <= '0;
      div <= DIV_WIDTH'(DIV_RESET);
      ovr <= 1'b0;
      fe <= 1'b0;
      int_o <= 1'b0;
    end else begin
      wb_ack_o <= term & adr_ok;
      wb_err_o <= term & ~adr_ok;
      if (rd) wb_dat_o <= rdata;
      if (wr && adr == 3'd1) ier <= wb_dat_i[1:0];
      if (wr && adr == 3'd2) div[7:0] <= wb_dat_i;
      if (wr && adr == 3'd3) div[DIV_WIDTH-1:8] <= (DIV_WIDTH-8)'(wb_dat_i);
      ovr <= (rx_stop & rx_full & ~rx_pop) | (ovr & ~(rd & adr == 3'd5));
      fe <= (rx_stop & ~rx_in) | (fe & ~(rd & adr == 3'd5));
      int_o <= (ier[0] & ~rx_empty) | (ier[1] & tx_empty);
    end
endmodule

// File: tb/tb_wb_uart_fifo.sv
// tb_wb_uart_fifo: directed register table plus serial TX/RX sequences for wb_uart_fifo.
module tb_wb_uart_fifo;
  logic clk = 1'b0, rst = 1'b1;
  logic [31:0] adr = '0;
  logic [7:0] dat_i = '0, dat_o;
  logic we = 1'b0, cyc = 1'b0, stb = 1'b0, ack, err, rty, irq, rx = 1'b1, tx;
  int n_vec = 0, n_bad = 0, frames = 0;
  logic tx_q = 1'b1;
  always #5 clk = ~clk;
  wb_uart_fifo dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr), .wb_dat_i(dat_i), .wb_we_i(we),
    .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_cti_i(3'b000), .wb_bte_i(2'b00),
    .wb_dat_o(dat_o), .wb_ack_o(ack), .wb_err_o(err), .wb_rty_o(rty), .int_o(irq),
    .rx(rx), .tx(tx)
  );
  always @(posedge clk) begin
    tx_q <= tx;
    if (tx_q & ~tx) frames <= frames + 1;
  end
  typedef struct {
    logic we; logic [2:0] adr; logic [7:0] wd; logic [7:0] rd; logic ack; logic err; logic irq;
  } vec_t;
  vec_t v [15];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask
  task automatic bus(input logic w, input logic [2:0] a, input logic [7:0] d,
                     output logic [7:0] q, output logic ak, output logic er);
    cyc = 1'b1; stb = 1'b1; we = w; adr = {29'b0, a}; dat_i = d;
    q = '0; ak = 1'b0; er = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ack | err) begin
        ak = ack; er = err; q = dat_o;
        break;
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask
  task automatic rd(input logic [2:0] a, input logic [7:0] e, input string n);
    logic [7:0] q;
    logic ak, er;
    bus(1'b0, a, 8'h00, q, ak, er);
    check({n, " ack"}, 32'(ak), 32'd1);
    check(n, 32'(q), 32'(e));
  endtask
  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    logic [7:0] q;
    logic ak, er;
    bus(1'b1, a, d, q, ak, er);
    check($sformatf("write adr%0d ack", a), 32'(ak), 32'd1);
  endtask
  task automatic send(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (8) @(negedge clk);
    end
    rx = stop;
    repeat (8) @(negedge clk);
    rx = 1'b1;
    repeat (2) @(negedge clk);
  endtask
  task automatic wait_tx_low(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (tx == 1'b0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
  initial begin
    logic [7:0] q;
    logic ak, er, ok;
    logic [9:0] frame;
    int acks, f0;
    v[0]  = '{1'b0, 3'd5, 8'h00, 8'h60, 1'b1, 1'b0, 1'b0};
    v[1]  = '{1'b0, 3'd0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0};
    v[2]  = '{1'b0, 3'd4, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0};
    v[3]  = '{1'b0, 3'd6, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0};
    v[4]  = '{1'b1, 3'd7, 8'h5A, 8'h00, 1'b0, 1'b1, 1'b0};
    v[5]  = '{1'b1, 3'd1, 8'h83, 8'h00, 1'b1, 1'b0, 1'b0};
    v[6]  = '{1'b0, 3'd1, 8'h00, 8'h03, 1'b1, 1'b0, 1'b1};
    v[7]  = '{1'b1, 3'd2, 8'h04, 8'h00, 1'b1, 1'b0, 1'b1};
    v[8]  = '{1'b1, 3'd3, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1};
    v[9]  = '{1'b0, 3'd2, 8'h00, 8'h04, 1'b1, 1'b0, 1'b1};
    v[10] = '{1'b0, 3'd3, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1};
    v[11] = '{1'b1, 3'd5, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b1};
    v[12] = '{1'b0, 3'd5, 8'h00, 8'h60, 1'b1, 1'b0, 1'b1};
    v[13] = '{1'b1, 3'd1, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1};
    v[14] = '{1'b0, 3'd1, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0};
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset tx", 32'(tx), 32'd1);
    check("reset int_o", 32'(irq), 32'd0);
    check("reset ack", 32'(ack), 32'd0);
    check("reset err", 32'(err), 32'd0);
    check("reset dat_o", 32'(dat_o), 32'd0);
    for (int i = 0; i < 15; i++) begin
      bus(v[i].we, v[i].adr, v[i].wd, q, ak, er);
      check($sformatf("vec%0d ack", i), 32'(ak), 32'(v[i].ack));
      check($sformatf("vec%0d err", i), 32'(er), 32'(v[i].err));
      check($sformatf("vec%0d int_o", i), 32'(irq), 32'(v[i].irq));
      if (!v[i].we && v[i].ack) check($sformatf("vec%0d data", i), 32'(q), 32'(v[i].rd));
    end
    // 0x55 at DIV=4: each bit checked at its first and last clock
    wr(3'd0, 8'h55);
    wait_tx_low(ok);
    check("tx start seen", 32'(ok), 32'd1);
    frame = {1'b1, 8'h55, 1'b0};
    for (int o = 0; o < 40; o++) begin
      if (o % 4 == 0 || o % 4 == 3) check($sformatf("tx 0x55 clk%0d", o), 32'(tx), 32'(frame[o / 4]));
      @(negedge clk);
    end
    rd(3'd5, 8'h60, "lsr after tx");
    wr(3'd2, 8'h08);
    wr(3'd1, 8'h01);
    check("int_o rx empty", 32'(irq), 32'd0);
    send(8'hA3, 1'b1);
    check("int_o rx byte", 32'(irq), 32'd1);
    rd(3'd5, 8'h61, "lsr rx byte");
    rd(3'd0, 8'hA3, "rx 0xA3");
    rd(3'd5, 8'h60, "lsr rx drained");
    @(negedge clk);
    check("int_o drained", 32'(irq), 32'd0);
    send(8'h3C, 1'b0);
    rd(3'd5, 8'h69, "lsr framing");
    rd(3'd5, 8'h61, "lsr framing cleared");
    rd(3'd0, 8'h3C, "rx framed byte");
    rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    rd(3'd5, 8'h60, "lsr false start");
    rd(3'd0, 8'h00, "rx empty read");
    for (int i = 0; i < 17; i++) send(8'h10 + 8'(i), 1'b1);
    rd(3'd5, 8'h63, "lsr overrun");
    rd(3'd5, 8'h61, "lsr overrun cleared");
    for (int i = 0; i < 16; i++) rd(3'd0, 8'h10 + 8'(i), $sformatf("rx fifo %0d", i));
    rd(3'd5, 8'h60, "lsr fifo drained");
    // held strobe: one write every 2nd cycle, 18 bytes of 0xFF
    f0 = frames;
    acks = 0;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = '0; dat_i = 8'hFF;
    for (int i = 0; i < 100 && acks < 18; i++) begin
      @(negedge clk);
      if (ack) acks++;
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    check("burst acks", 32'(acks), 32'd18);
    rd(3'd5, 8'h10, "lsr tx full");
    repeat (17 * 80 + 200) @(negedge clk);
    check("tx frames sent", 32'(frames - f0), 32'd17);
    rd(3'd5, 8'h60, "lsr tx drained");
    wr(3'd0, 8'h00);
    wait_tx_low(ok);
    check("tx start before reset", 32'(ok), 32'd1);
    rst = 1'b1;
    #1;
    check("tx async reset", 32'(tx), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rd(3'd5, 8'h60, "lsr after reset");
    rd(3'd2, 8'hB2, "divl reset");
    rd(3'd3, 8'h01, "divh reset");
    rd(3'd1, 8'h00, "ier reset");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
